reg_file_mp: RTL and testbench

Parametrised multi-port register file: the next generation of the single-port `reg_file`, for CPU datapaths needing two operand reads and two writebacks per cycle. Adds asynchronous reset, registered reads with per-port enable and valid, write-to-read bypass, deterministic write-port priority, and an optional hardwired-zero register 0.

---
 rtl/reg_file_mp_pkg.sv | 16 +
 rtl/reg_file_rd_port.sv | 69 ++++++
 rtl/reg_file_mp.sv | 78 +++++++
 tb/tb_reg_file_mp.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file and its read ports.
package reg_file_mp_pkg;

  localparam int ZERO_REG_DEFAULT = 0;

  // Address width; never below 1 so a 2-entry file still has an address bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // An address is usable when it names a real entry and is not the hardwired zero register.
  function automatic logic addr_legal(input int unsigned a, input int unsigned n, input logic zr);
    return (a < n) && !(zr && (a == 0));
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: legality check, zero masking, write-first bypass, output/valid registers.
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  parameter  int SIZE     = 32,
  parameter  int ZERO_REG = ZERO_REG_DEFAULT,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rd_en_i,
  input  logic [AW-1:0]            rd_addr_i,
  input  logic                     wr0_ok_i,
  input  logic [AW-1:0]            wr0_addr_i,
  input  logic [SIZE-1:0]          wr0_data_i,
  input  logic                     wr1_ok_i,
  input  logic [AW-1:0]            wr1_addr_i,
  input  logic [SIZE-1:0]          wr1_data_i,
  input  logic [NUM_REGS*SIZE-1:0] regs_d_i,
  output logic [SIZE-1:0]          rd_data_o,
  output logic                     rd_valid_o
);

  logic            legal;
  logic            hit0;
  logic            hit1;
  logic [SIZE-1:0] arr_val;
  logic [SIZE-1:0] data_d, data_q;
  logic            valid_d, valid_q;

  assign legal = addr_legal(32'(rd_addr_i), NUM_REGS, ZERO_REG != 0);
  assign hit0  = wr0_ok_i && (wr0_addr_i == rd_addr_i);
  assign hit1  = wr1_ok_i && (wr1_addr_i == rd_addr_i);

  always_comb begin
    arr_val = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_addr_i == AW'(r)) arr_val = regs_d_i[r*SIZE +: SIZE];
    end
  end

  // Port 1 wins over port 0, matching the store order in the array.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (rd_en_i) begin
      valid_d = 1'b1;
      if (!legal)    data_d = '0;
      else if (hit1) data_d = wr1_data_i;
      else if (hit0) data_d = wr0_data_i;
      else           data_d = arr_val;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD registered read ports with bypass.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  parameter  int SIZE     = 32,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = ZERO_REG_DEFAULT,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr0_en,
  input  logic [AW-1:0]          wr0_addr,
  input  logic [SIZE-1:0]        wr0_data,
  input  logic                   wr1_en,
  input  logic [AW-1:0]          wr1_addr,
  input  logic [SIZE-1:0]        wr1_data,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*SIZE-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_valid
);

  logic [SIZE-1:0]          regs_q [NUM_REGS];
  logic [SIZE-1:0]          regs_d [NUM_REGS];
  logic [NUM_REGS*SIZE-1:0] regs_flat_d;
  logic                     wr0_ok;
  logic                     wr1_ok;

  assign wr0_ok = wr0_en && addr_legal(32'(wr0_addr), NUM_REGS, ZERO_REG != 0);
  assign wr1_ok = wr1_en && addr_legal(32'(wr1_addr), NUM_REGS, ZERO_REG != 0);

  // Port 1 is applied last so it overrides port 0 on a same-address collision.
  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr0_ok && (wr0_addr == AW'(r))) regs_d[r] = wr0_data;
      if (wr1_ok && (wr1_addr == AW'(r))) regs_d[r] = wr1_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    regs_flat_d = '0;
    for (int r = 0; r < NUM_REGS; r++) regs_flat_d[r*SIZE +: SIZE] = regs_d[r];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rd_port #(
      .NUM_REGS (NUM_REGS),
      .SIZE     (SIZE),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk_i      (clk),
      .rst_i      (rst),
      .rd_en_i    (rd_en[p]),
      .rd_addr_i  (rd_addr[p*AW +: AW]),
      .wr0_ok_i   (wr0_ok),
      .wr0_addr_i (wr0_addr),
      .wr0_data_i (wr0_data),
      .wr1_ok_i   (wr1_ok),
      .wr1_addr_i (wr1_addr),
      .wr1_data_i (wr1_data),
      .regs_d_i   (regs_flat_d),
      .rd_data_o  (rd_data[p*SIZE +: SIZE]),
      .rd_valid_o (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: instance A (16 regs) and instance B (12 regs, zero register).
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_wr0_en, a_wr1_en, b_wr0_en, b_wr1_en;
  logic [3:0]  a_wr0_addr, a_wr1_addr, b_wr0_addr, b_wr1_addr;
  logic [31:0] a_wr0_data, a_wr1_data, b_wr0_data, b_wr1_data;
  logic [1:0]  a_rd_en, b_rd_en, a_rd_valid, b_rd_valid;
  logic [7:0]  a_rd_addr, b_rd_addr;
  logic [63:0] a_rd_data, b_rd_data;

  reg_file_mp #(.NUM_REGS(16), .SIZE(32), .NUM_RD(2), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst),
    .wr0_en(a_wr0_en), .wr0_addr(a_wr0_addr), .wr0_data(a_wr0_data),
    .wr1_en(a_wr1_en), .wr1_addr(a_wr1_addr), .wr1_data(a_wr1_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  reg_file_mp #(.NUM_REGS(12), .SIZE(32), .NUM_RD(2), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst),
    .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
    .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [4][$];
  logic [31:0] last_exp [4];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic idle();
    a_wr0_en = 0; a_wr1_en = 0; b_wr0_en = 0; b_wr1_en = 0;
    a_rd_en = '0; b_rd_en = '0;
  endtask

  task automatic cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input int inst, input int port, input int addr, input logic [31:0] d);
    if (inst == 0) begin
      if (port == 0) begin a_wr0_en = 1; a_wr0_addr = 4'(addr); a_wr0_data = d; end
      else           begin a_wr1_en = 1; a_wr1_addr = 4'(addr); a_wr1_data = d; end
    end else begin
      if (port == 0) begin b_wr0_en = 1; b_wr0_addr = 4'(addr); b_wr0_data = d; end
      else           begin b_wr1_en = 1; b_wr1_addr = 4'(addr); b_wr1_data = d; end
    end
  endtask

  task automatic rd(input int inst, input int port, input int addr, input logic [31:0] exp);
    if (inst == 0) begin
      a_rd_en[port] = 1'b1; a_rd_addr[port*4 +: 4] = 4'(addr);
    end else begin
      b_rd_en[port] = 1'b1; b_rd_addr[port*4 +: 4] = 4'(addr);
    end
    exp_q[inst*2+port].push_back(exp);
  endtask

  // Monitor: pops an expectation whenever a port shows valid, else checks the held value.
  logic [3:0]  mon_vld;
  logic [31:0] mon_dat [4];
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    mon_vld    = {b_rd_valid, a_rd_valid};
    mon_dat[0] = a_rd_data[31:0];
    mon_dat[1] = a_rd_data[63:32];
    mon_dat[2] = b_rd_data[31:0];
    mon_dat[3] = b_rd_data[63:32];
    if (rst) begin
      for (int i = 0; i < 4; i++) last_exp[i] = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mon_vld[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_valid_p%0d", i), 32'(mon_vld[i]), 32'd0);
          end else begin
            mon_exp = exp_q[i].pop_front();
            chk($sformatf("rd_data_p%0d", i), mon_dat[i], mon_exp);
            last_exp[i] = mon_exp;
          end
        end else begin
          chk($sformatf("hold_p%0d", i), mon_dat[i], last_exp[i]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_wr0_addr = '0; a_wr1_addr = '0; b_wr0_addr = '0; b_wr1_addr = '0;
    a_wr0_data = '0; a_wr1_data = '0; b_wr0_data = '0; b_wr1_data = '0;
    a_rd_addr = '0; b_rd_addr = '0;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Test 1: fill with 0xFF, make outputs nonzero, then reset mid-cycle.
    for (int i = 0; i < 16; i += 2) begin
      cycle(); wr(0, 0, i, 32'hFF); wr(0, 1, i + 1, 32'hFF);
    end
    cycle(); rd(0, 0, 0, 32'hFF); rd(0, 1, 15, 32'hFF);
    cycle();
    #2 rst = 1'b1;
    wr(0, 0, 7, 32'h33);
    #1;
    chk("rst_data_p0", a_rd_data[31:0], 32'h0);
    chk("rst_data_p1", a_rd_data[63:32], 32'h0);
    chk("rst_valid", 32'(a_rd_valid), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    idle();
    for (int i = 0; i < 16; i += 2) begin
      cycle(); rd(0, 0, i, 32'h0); rd(0, 1, i + 1, 32'h0);
    end

    // Test 2: dual write to distinct addresses.
    cycle(); wr(0, 0, 1, 32'hFE); wr(0, 1, 15, 32'h5A);
    cycle(); rd(0, 0, 1, 32'hFE); rd(0, 1, 15, 32'h5A);

    // Test 3: same-address collision, port 1 wins.
    cycle(); wr(0, 0, 2, 32'hAA); wr(0, 1, 2, 32'h55);
    cycle(); rd(0, 0, 2, 32'h55); rd(0, 1, 2, 32'h55);

    // Test 4: write-first bypass on each port, then bypass priority.
    cycle(); wr(0, 0, 3, 32'h1111); wr(0, 1, 4, 32'h2222);
    cycle(); rd(0, 0, 3, 32'h1111); rd(0, 1, 4, 32'h2222);
    cycle(); wr(0, 0, 3, 32'h1234); rd(0, 0, 3, 32'h1234);
             wr(0, 1, 4, 32'h9);    rd(0, 1, 4, 32'h9);
    cycle(); rd(0, 0, 3, 32'h1234); rd(0, 1, 4, 32'h9);
    cycle(); wr(0, 0, 5, 32'hA); wr(0, 1, 5, 32'hB); rd(0, 0, 5, 32'hB);
    cycle(); rd(0, 1, 5, 32'hB);

    // Test 6: hold while disabled, then fresh value on re-enable.
    cycle(); rd(0, 0, 1, 32'hFE);
    cycle(); wr(0, 0, 1, 32'h77);
    cycle();
    cycle(); rd(0, 0, 1, 32'h77);

    // Test 5: instance B, zero register and out-of-range address.
    for (int i = 1; i <= 11; i += 2) begin
      cycle(); wr(1, 0, i, 32'h100 + 32'(i));
      if (i + 1 <= 11) wr(1, 1, i + 1, 32'h100 + 32'(i + 1));
    end
    cycle(); wr(1, 0, 0, 32'hDEAD); wr(1, 1, 13, 32'hBEEF);
             rd(1, 0, 0, 32'h0);    rd(1, 1, 13, 32'h0);
    cycle(); rd(1, 0, 0, 32'h0); rd(1, 1, 13, 32'h0);
    for (int i = 1; i <= 11; i += 2) begin
      cycle(); rd(1, 0, i, 32'h100 + 32'(i));
      rd(1, 1, i + 1, (i + 1 <= 11) ? 32'h100 + 32'(i + 1) : 32'h0);
    end

    cycle();
    cycle();
    for (int i = 0; i < 4; i++) chk($sformatf("drain_p%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
